// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses A5/ADDR/DATA/CSUM frames from the RX byte stream and drives the LEDs.
// Optional LED blinking (blink_div register at ADDR 0x01) is built only when UART_CMD_BLINK_EN is defined.
module uart_cmd_ctrl #(
  parameter int unsigned      LED_W         = 8,
  parameter logic [LED_W-1:0] LED_RST       = '0,
  parameter int unsigned      TIMEOUT_BAUDS = 16,
  parameter int unsigned      BLINK_SCALE   = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             baud_pulse,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             cmd_ok,
  output logic             cmd_err,
  output logic [1:0]       err_code
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_BAUDS + 1);
  localparam logic [7:0]  HDR  = 8'hA5;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ADDR    = 2'b11;

  localparam logic [7:0] ADDR_LED   = 8'h00;
  localparam logic [7:0] ADDR_BLINK = 8'h01;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM} state_t;

  state_t           state;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic [LED_W-1:0] led_q;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       csum;
  logic             timeout_hit;

  assign csum = addr_q + data_q;
  assign busy = (state != S_IDLE);

  // A byte arriving on the same cycle as the final tick keeps the frame alive.
  assign timeout_hit = (state != S_IDLE) && baud_pulse && !byte_valid &&
                       (to_cnt == TO_W'(TIMEOUT_BAUDS - 1));

  // NOTE: every register uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      led_q    <= LED_RST;
      to_cnt   <= '0;
      cmd_ok   <= 1'b0;
      cmd_err  <= 1'b0;
      err_code <= '0;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;

      if (byte_valid || state == S_IDLE) begin
        to_cnt <= '0;
      end else if (baud_pulse) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (timeout_hit) begin
        state    <= S_IDLE;
        cmd_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (byte_valid) begin
        unique case (state)
          S_IDLE: if (byte_in == HDR) state <= S_ADDR;
          S_ADDR: begin
            addr_q <= byte_in;
            state  <= S_DATA;
          end
          S_DATA: begin
            data_q <= byte_in;
            state  <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_IDLE;
            if (byte_in != csum) begin
              cmd_err  <= 1'b1;
              err_code <= ERR_CSUM;
            end else if (addr_q == ADDR_LED) begin
              led_q  <= data_q[LED_W-1:0];
              cmd_ok <= 1'b1;
            end else if (addr_q == ADDR_BLINK) begin
              cmd_ok <= 1'b1;
            end else begin
              cmd_err  <= 1'b1;
              err_code <= ERR_ADDR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_CMD_BLINK_EN
  localparam int unsigned PS_W = 8 + $clog2(BLINK_SCALE) + 1;

  logic [7:0]      blink_div;
  logic [PS_W-1:0] prescale;
  logic [PS_W-1:0] blink_limit;
  logic            phase;
  logic            blink_wr;

  assign blink_limit = PS_W'(blink_div) * PS_W'(BLINK_SCALE);
  assign blink_wr    = byte_valid && !timeout_hit && (state == S_CSUM) &&
                       (byte_in == csum) && (addr_q == ADDR_BLINK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_div <= '0;
      prescale  <= '0;
      phase     <= 1'b0;
    end else if (blink_wr) begin
      blink_div <= data_q;
      prescale  <= '0;
      phase     <= 1'b0;
    end else if (blink_div == '0) begin
      prescale <= '0;
      phase    <= 1'b0;
    end else if (baud_pulse) begin
      if (prescale == blink_limit - PS_W'(1)) begin
        prescale <= '0;
        phase    <= ~phase;
      end else begin
        prescale <= prescale + PS_W'(1);
      end
    end
  end

  assign led = phase ? '0 : led_q;
`else
  assign led = led_q;
`endif

endmodule
